tdc_result_packer: RTL and testbench

//  Downstream of the TDC core: accepts 40-bit measurement words (meas_valid pulses),

---
 rtl/tdc_result_packer.sv | 177 +++++++++++++++++
 tb/tb_tdc_result_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tdc_result_packer.sv
// TDC result packer: buffers 40-bit measurement words in a FIFO and serialises
// each one as a 7-byte frame (sync, 5 data bytes, XOR checksum) onto a
// valid/ready byte stream. Words that arrive while the FIFO is full are dropped
// and counted.
module tdc_result_packer #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [39:0]       meas_in,
    input  logic              meas_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic [7:0]        drop_count,
    input  logic              clear_overflow
);

    localparam int unsigned DEPTH  = 2**ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned MEAS_W = 40;
    localparam int unsigned IDX_W  = 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);

    logic [MEAS_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [MEAS_W-1:0] frame_q, frame_d;
    logic [7:0]        chk_q, chk_d;
    logic              tx_valid_d;
    logic [7:0]        tx_data_d;

    logic              fifo_empty_c;
    logic              fifo_full_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic [MEAS_W-1:0] head_c;

    assign fifo_empty_c = (fifo_count == CNT_W'(0));
    assign fifo_full_c  = (fifo_count == CNT_W'(DEPTH));
    assign pop_c        = (state_q == S_IDLE) && !fifo_empty_c;
    assign push_c       = meas_valid && (!fifo_full_c || pop_c);
    assign drop_c       = meas_valid && fifo_full_c && !pop_c;
    assign head_c       = mem[rd_ptr];

    // Select one byte of the latched frame by its position in the frame
    function automatic logic [7:0] frame_byte(input logic [MEAS_W-1:0] w,
                                              input logic [7:0]        chk,
                                              input logic [IDX_W-1:0]  idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            IDX_W'(0): b = SYNC_BYTE;
            IDX_W'(1): b = w[39:32];
            IDX_W'(2): b = w[31:24];
            IDX_W'(3): b = w[23:16];
            IDX_W'(4): b = w[15:8];
            IDX_W'(5): b = w[7:0];
            IDX_W'(6): b = chk;
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

    // FIFO storage; no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= meas_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= ADDR_W'(wr_ptr + 1'b1);
            end
            if (pop_c) begin
                rd_ptr <= ADDR_W'(rd_ptr + 1'b1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= CNT_W'(fifo_count + 1'b1);
                2'b01:   fifo_count <= CNT_W'(fifo_count - 1'b1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop in the clear cycle survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else if (clear_overflow) begin
            overflow   <= drop_c;
            drop_count <= drop_c ? 8'h01 : 8'h00;
        end else if (drop_c) begin
            overflow   <= 1'b1;
            drop_count <= (drop_count == 8'hFF) ? 8'hFF : 8'(drop_count + 8'h01);
        end
    end

    // FSM state, frame register and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            frame_q  <= '0;
            chk_q    <= 8'h00;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            chk_q    <= chk_d;
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
        end
    end

    // Next-state logic: latch and pop a word in IDLE, step through bytes on each handshake in SEND
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        chk_d      = chk_q;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (pop_c) begin
                    frame_d    = head_c;
                    chk_d      = head_c[39:32] ^ head_c[31:24] ^ head_c[23:16]
                               ^ head_c[15:8]  ^ head_c[7:0];
                    idx_d      = '0;
                    state_d    = S_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            S_SEND: begin
                tx_valid_d = 1'b1;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                    end else begin
                        idx_d     = IDX_W'(idx_q + 1'b1);
                        tx_data_d = frame_byte(frame_q, chk_q, IDX_W'(idx_q + 1'b1));
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tdc_result_packer.sv
// Bench for tdc_result_packer: a queue-based reference model predicts the byte
// stream and status outputs; a negedge monitor compares against a scoreboard.
module tb_tdc_result_packer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [39:0]       meas_in;
    logic              meas_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic [7:0]        drop_count;
    logic              clear_overflow;

    int checks = 0;
    int errors = 0;

    tdc_result_packer #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .meas_valid(meas_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: words waiting, frame in flight as a byte countdown
    logic [39:0] mq[$];
    logic [7:0]  sb[$];
    logic [7:0]  got[$];
    bit          m_busy;
    int          m_rem;
    bit          m_ovf;
    int          m_dc;

    always @(posedge clk or negedge rst_n) begin
        bit pop, acc, drop;
        logic [39:0] w;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            m_busy = 0;
            m_rem  = 0;
            m_ovf  = 0;
            m_dc   = 0;
        end else begin
            pop  = !m_busy && (mq.size() > 0);
            acc  = meas_valid && ((mq.size() < DEPTH) || pop);
            drop = meas_valid && !acc;
            if (m_busy && tx_ready) begin
                m_rem--;
                if (m_rem == 0) m_busy = 0;
            end
            if (pop) begin
                w = mq.pop_front();
                m_busy = 1;
                m_rem  = 7;
            end
            if (acc) begin
                mq.push_back(meas_in);
                sb.push_back(8'hA5);
                for (int k = 4; k >= 0; k--) sb.push_back(meas_in[k*8 +: 8]);
                sb.push_back(meas_in[39:32] ^ meas_in[31:24] ^ meas_in[23:16]
                             ^ meas_in[15:8] ^ meas_in[7:0]);
            end
            if (clear_overflow) begin
                m_ovf = drop;
                m_dc  = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1;
                m_dc  = (m_dc >= 255) ? 255 : m_dc + 1;
            end
        end
    end

    // Monitor: compare status every cycle and each presented byte against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx_valid", 64'(tx_valid), 64'(m_busy));
            chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_count", 64'(drop_count), 64'(m_dc));
            if (tx_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", 64'(tx_data), 64'hFFFF_FFFF);
                end else begin
                    chk("tx_data", 64'(tx_data), 64'(sb[0]));
                    if (tx_ready) begin
                        got.push_back(tx_data);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic mv, input logic [39:0] d, input logic rdy, input logic clr);
        meas_valid     = mv;
        meas_in        = d;
        tx_ready       = rdy;
        clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || m_busy || mq.size() != 0) && n < 400) begin
            step(1'b0, 40'h0, 1'b1, 1'b0);
            n++;
        end
        chk({nm, "_drain_left"}, 64'(sb.size()), 64'd0);
    endtask

    logic [7:0] t1_exp [7];

    initial begin
        t1_exp = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67};
        rst_n = 1'b0;
        meas_valid = 1'b0; meas_in = '0; tx_ready = 1'b0; clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_valid", 64'(tx_valid), 64'd0);
        chk("reset_tx_data", 64'(tx_data), 64'd0);
        chk("reset_fifo_count", 64'(fifo_count), 64'd0);
        chk("reset_drop_count", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        step(1'b0, 40'h0, 1'b1, 1'b0);

        // Single word, always ready
        got.delete();
        step(1'b1, 40'h0000012345, 1'b1, 1'b0);
        drain("t1");
        chk("t1_nbytes", 64'(got.size()), 64'd7);
        for (int i = 0; i < 7; i++)
            if (i < got.size()) chk("t1_byte", 64'(got[i]), 64'(t1_exp[i]));

        // Same word with ready asserted one cycle in three
        got.delete();
        step(1'b1, 40'h0000012345, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 40'h0, (i % 3) == 2, 1'b0);
        drain("t2");
        chk("t2_nbytes", 64'(got.size()), 64'd7);
        for (int i = 0; i < 7; i++)
            if (i < got.size()) chk("t2_byte", 64'(got[i]), 64'(t1_exp[i]));

        // Overflow with a stalled transmitter, then the clear/drop race and saturation
        for (int i = 0; i < 18; i++) step(1'b1, 40'(64'h100 + i), 1'b0, 1'b0);
        step(1'b0, 40'h0, 1'b0, 1'b0);
        chk("t3_fifo_count", 64'(fifo_count), 64'd16);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_drop_count", 64'(drop_count), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 40'(64'hDEAD00 + i), 1'b0, 1'b0);
        chk("t4_drop5", 64'(drop_count), 64'd5);
        step(1'b1, 40'hBAD0000001, 1'b0, 1'b1);
        chk("t4_clear_overflow", 64'(overflow), 64'd1);
        chk("t4_clear_drop_count", 64'(drop_count), 64'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 40'($urandom), 1'b0, 1'b0);
        chk("t4_saturated", 64'(drop_count), 64'hFF);
        got.delete();
        drain("t3");
        chk("t3_frames", 64'(got.size()), 64'd119);
        for (int f = 0; f < 17; f++)
            if (f * 7 + 5 < got.size()) chk("t3_order", 64'(got[f*7 + 5]), 64'(8'(f)));
        step(1'b0, 40'h0, 1'b1, 1'b1);

        // Push coincident with pop of a single buffered word
        step(1'b1, 40'h11_2233_4455, 1'b1, 1'b0);
        step(1'b1, 40'h66_7788_99AA, 1'b1, 1'b0);
        chk("t5_fifo_count", 64'(fifo_count), 64'd1);
        drain("t5");

        // Reset in the middle of a frame with four words queued
        for (int i = 0; i < 5; i++) step(1'b1, 40'($urandom), 1'b1, 1'b0);
        step(1'b0, 40'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_tx_valid", 64'(tx_valid), 64'd0);
        chk("t6_fifo_count", 64'(fifo_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 40'h0, 1'b1, 1'b0);

        // Randomised traffic at several arrival rates and ready densities
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1000; i++)
                step($urandom_range(9, 0) < (2 + ph * 2), 40'({$urandom, $urandom}),
                     $urandom_range(3, 0) < (3 - ph % 2 * 2), $urandom_range(63, 0) == 0);
            drain("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
